// File: rtl/reg_commit_sched_pkg.sv
// rtl/reg_commit_sched_pkg.sv - shared widths, constants, states and entry layout for the commit scheduler
package reg_commit_sched_pkg;

    localparam int REG_POS_W = 5;
    localparam int ROB_ID_W  = 4;
    localparam int DATA_W    = 32;

    localparam logic [REG_POS_W-1:0] ZERO_REG  = '0;
    localparam logic [ROB_ID_W-1:0]  ZERO_ROB  = '0;
    localparam logic [DATA_W-1:0]    ZERO_WORD = '0;

    typedef enum logic [1:0] {
        SCHED_RUN     = 2'd0,
        SCHED_FLUSH   = 2'd1,
        SCHED_RECOVER = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [REG_POS_W-1:0] rd;
        logic [ROB_ID_W-1:0]  rob_id;
        logic [DATA_W-1:0]    value;
        logic                 mispredict;
    } commit_entry_t;

    localparam int ENTRY_W = $bits(commit_entry_t);

endpackage

// File: rtl/commit_fifo.sv
// rtl/commit_fifo.sv - entry FIFO between ROB head and commit stage, with synchronous clear for flushes
module commit_fifo
    import reg_commit_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [ENTRY_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[head_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + PTR_ONE;
            end
            if (do_pop) begin
                head_ptr <= head_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_commit_sched.sv
// rtl/reg_commit_sched.sv - issues one register-file commit per cycle from buffered ROB retirements, flushing on mispredicts
module reg_commit_sched
    import reg_commit_sched_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_POS_W-1:0] in_rd,
    input  logic [ROB_ID_W-1:0]  in_rob_id,
    input  logic [DATA_W-1:0]    in_value,
    input  logic                 in_mispredict,
    output logic                 wb_commit_flag,
    output logic                 wb_jump_flag,
    output logic [REG_POS_W-1:0] wb_rd,
    output logic [ROB_ID_W-1:0]  wb_rob_id,
    output logic [DATA_W-1:0]    wb_value,
    output logic                 flush_out,
    output logic [31:0]          retire_cnt
);

    localparam int RC_W = $clog2(RECOVER_CYCLES + 1);
    localparam logic [RC_W-1:0] RECOVER_LOAD = RC_W'(RECOVER_CYCLES - 1);
    localparam logic [RC_W-1:0] RC_ONE       = RC_W'(1);

    sched_state_t       state;
    sched_state_t       state_next;
    logic [RC_W-1:0]    recover_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               clear;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_bits;
    commit_entry_t      head;

    assign in_entry = {in_rd, in_rob_id, in_value, in_mispredict};
    assign head     = head_bits;

    commit_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .push     (in_valid && in_ready),
        .push_data(in_entry),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head_bits)
    );

    // A mispredict at the head blocks intake so nothing behind it slips in on its pop edge.
    assign in_ready = !rst && (state == SCHED_RUN) && !fifo_full
                      && !(!fifo_empty && head.mispredict);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        clear      = 1'b0;
        case (state)
            SCHED_RUN: begin
                pop = !fifo_empty;
                if (pop && head.mispredict) begin
                    state_next = SCHED_FLUSH;
                end
            end
            SCHED_FLUSH: begin
                clear      = 1'b1;
                state_next = SCHED_RECOVER;
            end
            SCHED_RECOVER: begin
                if (recover_cnt == '0) begin
                    state_next = SCHED_RUN;
                end
            end
            default: state_next = SCHED_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SCHED_RUN;
            recover_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == SCHED_FLUSH) begin
                recover_cnt <= RECOVER_LOAD;
            end else if (state == SCHED_RECOVER && recover_cnt != '0) begin
                recover_cnt <= recover_cnt - RC_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_commit_flag <= 1'b0;
            wb_jump_flag   <= 1'b0;
            wb_rd          <= ZERO_REG;
            wb_rob_id      <= ZERO_ROB;
            wb_value       <= ZERO_WORD;
            flush_out      <= 1'b0;
            retire_cnt     <= 32'd0;
        end else begin
            wb_commit_flag <= pop && (head.rd != ZERO_REG);
            wb_jump_flag   <= pop && head.mispredict;
            flush_out      <= (state == SCHED_FLUSH);
            if (pop) begin
                wb_rd      <= head.rd;
                wb_rob_id  <= head.rob_id;
                wb_value   <= head.value;
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_commit_sched.sv
// tb/tb_reg_commit_sched.sv - self-checking bench for reg_commit_sched with a queue-based reference model
module tb_reg_commit_sched;
    import reg_commit_sched_pkg::*;

    localparam int DEPTH = 4;
    localparam int RC    = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [3:0]  in_rob_id;
    logic [31:0] in_value;
    logic        in_mispredict;
    logic        wb_commit_flag;
    logic        wb_jump_flag;
    logic [4:0]  wb_rd;
    logic [3:0]  wb_rob_id;
    logic [31:0] wb_value;
    logic        flush_out;
    logic [31:0] retire_cnt;

    logic               f_push;
    logic               f_pop;
    logic               f_clear;
    logic [ENTRY_W-1:0] f_data;
    logic               f_full;
    logic               f_empty;
    logic [ENTRY_W-1:0] f_head;
    commit_entry_t      fh;
    assign fh = f_head;

    reg_commit_sched #(.DEPTH(DEPTH), .RECOVER_CYCLES(RC)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_rob_id     (in_rob_id),
        .in_value      (in_value),
        .in_mispredict (in_mispredict),
        .wb_commit_flag(wb_commit_flag),
        .wb_jump_flag  (wb_jump_flag),
        .wb_rd         (wb_rd),
        .wb_rob_id     (wb_rob_id),
        .wb_value      (wb_value),
        .flush_out     (flush_out),
        .retire_cnt    (retire_cnt)
    );

    commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (f_clear),
        .push     (f_push),
        .push_data(f_data),
        .pop      (f_pop),
        .full     (f_full),
        .empty    (f_empty),
        .head     (f_head)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending entries plus a countdown of blocked cycles after a mispredict.
    typedef struct {
        logic [4:0]  rd;
        logic [3:0]  tag;
        logic [31:0] val;
        logic        mis;
    } ent_t;

    ent_t        q[$];
    int          busy;
    logic        exp_commit;
    logic        exp_jump;
    logic        exp_flush;
    logic [4:0]  exp_rd;
    logic [3:0]  exp_tag;
    logic [31:0] exp_val;
    logic [31:0] exp_retire;

    function automatic logic m_ready();
        return !rst && busy == 0 && q.size() < DEPTH && !(q.size() > 0 && q[0].mis);
    endfunction

    task automatic model_reset();
        q.delete();
        busy       = 0;
        exp_commit = 0;
        exp_jump   = 0;
        exp_flush  = 0;
        exp_rd     = 0;
        exp_tag    = 0;
        exp_val    = 0;
        exp_retire = 0;
    endtask

    task automatic model_edge();
        ent_t e;
        logic acc;
        acc        = in_valid && m_ready();
        exp_commit = 0;
        exp_jump   = 0;
        exp_flush  = 0;
        if (busy > 0) begin
            if (busy == RC + 1) begin
                exp_flush = 1;
                q.delete();
            end
            busy--;
        end else if (q.size() > 0) begin
            e          = q.pop_front();
            exp_commit = (e.rd != 0);
            exp_jump   = e.mis;
            exp_rd     = e.rd;
            exp_tag    = e.tag;
            exp_val    = e.val;
            exp_retire = exp_retire + 1;
            if (e.mis) busy = RC + 1;
        end
        if (acc) q.push_back('{in_rd, in_rob_id, in_value, in_mispredict});
    endtask

    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
        chk("wb_commit_flag", {31'd0, wb_commit_flag}, {31'd0, exp_commit});
        chk("wb_jump_flag", {31'd0, wb_jump_flag}, {31'd0, exp_jump});
        chk("flush_out", {31'd0, flush_out}, {31'd0, exp_flush});
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, exp_rd});
        chk("wb_rob_id", {28'd0, wb_rob_id}, {28'd0, exp_tag});
        chk("wb_value", wb_value, exp_val);
        chk("retire_cnt", retire_cnt, exp_retire);
    end

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [3:0] tag,
                         input logic [31:0] val, input logic mis);
        in_valid      = v;
        in_rd         = rd;
        in_rob_id     = tag;
        in_value      = val;
        in_mispredict = mis;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 4'd0, 32'd0, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        f_push  = 1'b0;
        f_pop   = 1'b0;
        f_clear = 1'b0;
        f_data  = '0;
        idle();
        model_reset();
        repeat (2) tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_commit", {31'd0, wb_commit_flag}, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Standalone FIFO: fill to full, drop an extra push, drain in order.
        for (int k = 1; k <= 4; k++) begin
            chk("fifo_not_full", {31'd0, f_full}, 32'd0);
            f_push = 1'b1;
            f_data = {5'd1, 4'(k), 32'(k), 1'b0};
            tick();
        end
        chk("fifo_full", {31'd0, f_full}, 32'd1);
        chk("fifo_nonempty", {31'd0, f_empty}, 32'd0);
        f_data = {5'd1, 4'd9, 32'd9, 1'b0};
        tick();
        f_push = 1'b0;
        f_pop  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("fifo_head_tag", {28'd0, fh.rob_id}, 32'(k));
            tick();
        end
        f_pop = 1'b0;
        chk("fifo_empty", {31'd0, f_empty}, 32'd1);

        // Single commit, two-edge latency.
        drive(1'b1, 5'd5, 4'd3, 32'hDEADBEEF, 1'b0);
        tick();
        idle();
        tick();
        chk("t1_commit", {31'd0, wb_commit_flag}, 32'd1);
        chk("t1_rd", {27'd0, wb_rd}, 32'd5);
        chk("t1_tag", {28'd0, wb_rob_id}, 32'd3);
        chk("t1_value", wb_value, 32'hDEADBEEF);
        chk("t1_retire", retire_cnt, 32'd1);
        tick();
        chk("t1_pulse", {31'd0, wb_commit_flag}, 32'd0);
        chk("t1_hold", wb_value, 32'hDEADBEEF);

        // rd=0 retires without a register write.
        drive(1'b1, 5'd0, 4'd2, 32'h1234, 1'b0);
        tick();
        idle();
        tick();
        chk("t2_commit", {31'd0, wb_commit_flag}, 32'd0);
        chk("t2_jump", {31'd0, wb_jump_flag}, 32'd0);
        chk("t2_tag", {28'd0, wb_rob_id}, 32'd2);
        chk("t2_retire", retire_cnt, 32'd2);

        // Back-to-back stream, one commit per cycle.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'(k + 8), 4'(k), 32'h1000 + 32'(k), 1'b0);
            tick();
        end
        idle();
        chk("t3_tag3", {28'd0, wb_rob_id}, 32'd3);
        tick();
        chk("t3_tag4", {28'd0, wb_rob_id}, 32'd4);
        chk("t3_retire", retire_cnt, 32'd6);
        tick();

        // Mispredict: tag 2 flushes, tags 3 and 4 never commit.
        drive(1'b1, 5'd7, 4'd1, 32'h77, 1'b0);
        tick();
        drive(1'b1, 5'd1, 4'd2, 32'h100, 1'b1);
        tick();
        chk("t4_block_at_head", {31'd0, in_ready}, 32'd0);
        chk("t4_tag1", {28'd0, wb_rob_id}, 32'd1);
        drive(1'b1, 5'd9, 4'd3, 32'h300, 1'b0);
        tick();
        chk("t4_jump", {31'd0, wb_jump_flag}, 32'd1);
        chk("t4_commit", {31'd0, wb_commit_flag}, 32'd1);
        chk("t4_tag2", {28'd0, wb_rob_id}, 32'd2);
        chk("t4_value", wb_value, 32'h100);
        chk("t4_retire", retire_cnt, 32'd8);
        drive(1'b1, 5'd10, 4'd4, 32'h400, 1'b0);
        tick();
        chk("t4_flush", {31'd0, flush_out}, 32'd1);
        chk("t4_jump_off", {31'd0, wb_jump_flag}, 32'd0);
        idle();
        tick();
        chk("t4_flush_off", {31'd0, flush_out}, 32'd0);
        chk("t4_recover_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t4_ready_back", {31'd0, in_ready}, 32'd1);
        repeat (2) tick();
        chk("t4_no_tag3", {28'd0, wb_rob_id}, 32'd2);
        chk("t4_retire_hold", retire_cnt, 32'd8);

        // Asynchronous reset while the flush pulse is high.
        drive(1'b1, 5'd3, 4'd5, 32'h55, 1'b1);
        tick();
        idle();
        tick();
        tick();
        chk("t5_flush", {31'd0, flush_out}, 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_async_flush", {31'd0, flush_out}, 32'd0);
        chk("t5_async_value", wb_value, 32'd0);
        chk("t5_async_tag", {28'd0, wb_rob_id}, 32'd0);
        chk("t5_async_retire", retire_cnt, 32'd0);
        chk("t5_async_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_ready", {31'd0, in_ready}, 32'd1);

        // Retire counter wraps at 2^32.
        force dut.retire_cnt = 32'hFFFFFFFF;
        exp_retire = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt;
        drive(1'b1, 5'd6, 4'd7, 32'hABC, 1'b0);
        tick();
        idle();
        tick();
        chk("t6_wrap", retire_cnt, 32'd0);
        chk("t6_commit", {31'd0, wb_commit_flag}, 32'd1);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
